// File: rtl/iob_out_driver.sv
// Output side of an I/O block: pad data/enable with serial config chain and turnaround FSM.
// Optional build macro IOB_OUT_INVERT_EN adds an INV config bit (chain MSB) that inverts PIN_O.
module iob_out_driver #(
  parameter int TA_W = 2
) (
  input  logic IOCLK,
  input  logic RSTN,
  input  logic CFG_SE,
  input  logic CFG_SI,
  output logic CFG_SO,
  input  logic OUT,
  input  logic TS,
  output logic PIN_O,
  output logic PIN_OE
);

`ifdef IOB_OUT_INVERT_EN
  localparam int CFG_W = 4 + TA_W;
`else
  localparam int CFG_W = 3 + TA_W;
`endif

  typedef enum logic [1:0] {
    S_HIZ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  logic [CFG_W-1:0] r_cfg;
  state_t           r_state;
  logic [TA_W-1:0]  r_cnt;
  logic             r_dreg;
  logic             r_oe;

  logic            w_doreg;
  logic [1:0]      w_tsmux;
  logic [TA_W-1:0] w_ta;
  logic            w_req;
  logic            w_inv;

  assign w_doreg = r_cfg[0];
  assign w_tsmux = r_cfg[2:1];
  assign w_ta    = r_cfg[TA_W+2:3];
  assign w_req   = (w_tsmux == 2'b01 && TS) || w_tsmux[1];

`ifdef IOB_OUT_INVERT_EN
  assign w_inv = r_cfg[CFG_W-1];
`else
  assign w_inv = 1'b0;
`endif

  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cfg <= '0;
    end else if (CFG_SE) begin
      r_cfg <= {CFG_SI, r_cfg[CFG_W-1:1]};
    end
  end

  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_dreg <= 1'b0;
    end else begin
      r_dreg <= OUT;
    end
  end

  // Turnaround FSM; r_oe is loaded with the decode of the next state so PIN_OE is a flop.
  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_HIZ;
      r_cnt   <= '0;
      r_oe    <= 1'b0;
    end else if (CFG_SE) begin
      r_state <= S_HIZ;
      r_cnt   <= '0;
      r_oe    <= 1'b0;
    end else begin
      case (r_state)
        S_HIZ: begin
          if (w_req) begin
            if (w_ta == '0) begin
              r_state <= S_DRIVE;
              r_oe    <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= w_ta;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_HIZ;
            r_oe    <= 1'b0;
          end else if (r_cnt == TA_W'(1)) begin
            r_state <= S_DRIVE;
            r_oe    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - TA_W'(1);
          end
        end
        S_DRIVE: begin
          if (!w_req) begin
            r_state <= S_HIZ;
            r_oe    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_HIZ;
          r_cnt   <= '0;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign CFG_SO = r_cfg[0];
  assign PIN_OE = r_oe;
  assign PIN_O  = (w_doreg ? r_dreg : OUT) ^ w_inv;

endmodule
